stk_al_ctrl: RTL

STK_AL_CTRL -- requirements
Module: stk_al_ctrl

---
 rtl/stk_al_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/stk_al_ctrl.sv
// Free-list allocator over an external 1R1W RAM holding a ring of free line IDs.
// Latency: alloc ID valid 1 cycle after accept; frees and init writes take effect at the next edge.
// Backpressure: alloc_rdy drops when empty, free_rdy when full, both low outside READY.
package stk_pkg;
    parameter int C_BANK_LINES_N = 8;
endpackage

module stk_al_ctrl #(
    parameter int LINES_N = stk_pkg::C_BANK_LINES_N,
    parameter int ID_W    = $clog2(LINES_N)
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic            i_init,
    output logic            o_busy_r,
    input  logic            i_alloc_vld,
    output logic            o_alloc_rdy,
    output logic            o_alloc_vld_r,
    output logic [ID_W-1:0] o_alloc_id_r,
    input  logic            i_free_vld,
    input  logic [ID_W-1:0] i_free_id,
    output logic            o_free_rdy,
    output logic            o_mem_ren,
    output logic [ID_W-1:0] o_mem_raddr,
    input  logic [ID_W-1:0] i_mem_rdata,
    output logic            o_mem_wen,
    output logic [ID_W-1:0] o_mem_waddr,
    output logic [ID_W-1:0] o_mem_wdata,
    output logic [ID_W:0]   o_cnt_r
);

    typedef enum logic [1:0] {
        ST_UNINIT = 2'd0,
        ST_INIT   = 2'd1,
        ST_READY  = 2'd2
    } state_t;

    localparam logic [ID_W:0]   CNT_FULL = (ID_W+1)'(LINES_N);
    localparam logic [ID_W-1:0] IDX_LAST = ID_W'(LINES_N - 1);
    localparam logic [ID_W-1:0] IDX_ONE  = ID_W'(1);

    state_t          state_r, state_nxt;
    logic [ID_W-1:0] widx_r, widx_nxt;
    logic [ID_W-1:0] head_r, head_nxt;
    logic [ID_W-1:0] tail_r, tail_nxt;
    logic [ID_W:0]   cnt_r, cnt_nxt;
    logic            pend_r;
    logic            alloc_acc;
    logic            free_acc;

    assign o_busy_r    = (state_r == ST_INIT);
    assign o_alloc_rdy = (state_r == ST_READY) && (cnt_r != '0);
    assign o_free_rdy  = (state_r == ST_READY) && (cnt_r != CNT_FULL);
    assign o_cnt_r     = cnt_r;

    // A restart wins over everything, including a handshake in the same cycle.
    assign alloc_acc = i_alloc_vld & o_alloc_rdy & ~i_init;
    assign free_acc  = i_free_vld & o_free_rdy & ~i_init;

    // The RAM returns data one cycle after the read; a restart in that cycle drops the result.
    assign o_alloc_vld_r = pend_r & ~i_init;
    assign o_alloc_id_r  = o_alloc_vld_r ? i_mem_rdata : '0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= ST_UNINIT;
            widx_r  <= '0;
            head_r  <= '0;
            tail_r  <= '0;
            cnt_r   <= '0;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_nxt;
            widx_r  <= widx_nxt;
            head_r  <= head_nxt;
            tail_r  <= tail_nxt;
            cnt_r   <= cnt_nxt;
            pend_r  <= alloc_acc;
        end
    end

    always_comb begin
        state_nxt   = state_r;
        widx_nxt    = widx_r;
        head_nxt    = head_r;
        tail_nxt    = tail_r;
        cnt_nxt     = cnt_r;
        o_mem_ren   = 1'b0;
        o_mem_raddr = head_r;
        o_mem_wen   = 1'b0;
        o_mem_waddr = tail_r;
        o_mem_wdata = i_free_id;

        if (i_init) begin
            state_nxt = ST_INIT;
            widx_nxt  = '0;
            head_nxt  = '0;
            tail_nxt  = '0;
            cnt_nxt   = '0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    // Seed the ring with the identity mapping, one entry per cycle.
                    o_mem_wen   = 1'b1;
                    o_mem_waddr = widx_r;
                    o_mem_wdata = widx_r;
                    if (widx_r == IDX_LAST) begin
                        state_nxt = ST_READY;
                        widx_nxt  = '0;
                        cnt_nxt   = CNT_FULL;
                    end else begin
                        widx_nxt = widx_r + IDX_ONE;
                    end
                end
                ST_READY: begin
                    if (alloc_acc) begin
                        o_mem_ren = 1'b1;
                        head_nxt  = head_r + IDX_ONE;
                    end
                    if (free_acc) begin
                        o_mem_wen = 1'b1;
                        tail_nxt  = tail_r + IDX_ONE;
                    end
                    case ({alloc_acc, free_acc})
                        2'b10:   cnt_nxt = cnt_r - 1'b1;
                        2'b01:   cnt_nxt = cnt_r + 1'b1;
                        default: cnt_nxt = cnt_r;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule
